// File: rtl/serial_subtractor_pkg.sv
// Shared types and default sizing for the digit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDigit = 8;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// master: the producer/consumer side; slave: the subtractor itself.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             of;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, bin, in_valid, out_ready,
    input  in_ready, diff, borrow, of, out_valid
  );

  modport slave (
    input  a, b, bin, in_valid, out_ready,
    output in_ready, diff, borrow, of, out_valid
  );

endinterface

// File: rtl/serial_subtractor_digit_sub.sv
// One DIGIT-bit subtract slice: a_k + ~b_k + carry_in.
// carry here is the inverted borrow (1 = no borrow).
module digit_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned DIGIT = DefaultDigit
) (
  input  logic [DIGIT-1:0] a_k,
  input  logic [DIGIT-1:0] b_k,
  input  logic             carry_in,
  output logic [DIGIT-1:0] digit,
  output logic             carry_out
);

  // Ripple add of the inverted subtrahend digit.
  always_comb begin
    {carry_out, digit} = {1'b0, a_k} + {1'b0, ~b_k} + {{DIGIT{1'b0}}, carry_in};
  end

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial two's complement subtractor: diff = a - b - bin, DIGIT bits per cycle,
// result after WIDTH/DIGIT cycles. WIDTH must be a multiple of DIGIT.
// Optional macro SERIAL_SUB_SAT_EN: saturate diff on signed overflow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DIGIT = DefaultDigit
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned NumDigits = WIDTH / DIGIT;
  localparam int unsigned CntW      = (NumDigits > 1) ? $clog2(NumDigits) : 1;
  localparam logic [CntW-1:0] LastDigit = CntW'(NumDigits - 1);

`ifdef SERIAL_SUB_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             of_q, of_d;

  logic [DIGIT-1:0] a_k;
  logic [DIGIT-1:0] b_k;
  logic [DIGIT-1:0] dig;
  logic             cout;
  logic             ovf;

  assign a_k = a_q[cnt_q*DIGIT +: DIGIT];
  assign b_k = b_q[cnt_q*DIGIT +: DIGIT];

  // The final digit carries the result MSB, so overflow is decided from it directly.
  assign ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dig[DIGIT-1] != a_q[WIDTH-1]);

  digit_sub #(
    .DIGIT(DIGIT)
  ) u_digit_sub (
    .a_k      (a_k),
    .b_k      (b_k),
    .carry_in (carry_q),
    .digit    (dig),
    .carry_out(cout)
  );

  // Next-state, datapath update and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    diff_d     = diff_q;
    carry_d    = carry_q;
    borrow_d   = borrow_q;
    of_d       = of_q;
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.diff      = diff_q;
    bus.borrow    = borrow_q;
    bus.of        = of_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = ~bus.bin;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        diff_d[cnt_q*DIGIT +: DIGIT] = dig;
        carry_d = cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastDigit) begin
          state_d  = StDone;
          borrow_d = ~cout;
          of_d     = ovf;
`ifdef SERIAL_SUB_SAT_EN
          if (ovf) begin
            diff_d = a_q[WIDTH-1] ? SatMin : SatMax;
          end
`endif
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      of_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      of_q     <= of_d;
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter DIGIT, default 8, bits processed per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 a  input  WIDTH  minuend, two's complement.
REQ-006 b  input  WIDTH  subtrahend, two's complement.
REQ-007 bin  input  1  borrow-in.
REQ-008 in_valid  input  1  operands present.
REQ-009 in_ready  output  1  block can accept operands.
REQ-010 diff  output  WIDTH  a - b - bin.
REQ-011 borrow  output  1  unsigned borrow-out.
REQ-012 of  output  1  signed overflow.
REQ-013 out_valid  output  1  diff, borrow and of are valid.
REQ-014 out_ready  input  1  consumer accepts the result.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; in_ready SHALL equal (state == IDLE).
REQ-016 IDLE: in_valid && in_ready at an edge SHALL latch a, b, bin, clear the digit counter, set internal carry = ~bin, and move to BUSY.
REQ-017 BUSY: each edge SHALL compute digit[k] = a_k + ~b_k + carry, store it into diff bits [k*DIGIT +: DIGIT], update carry, and increment k.
REQ-018 After digit WIDTH/DIGIT-1 is processed, FSM SHALL move to DONE; latency = WIDTH/DIGIT edges after the accept edge (4 at defaults).
REQ-019 On entering DONE: borrow = ~final carry; of = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
REQ-020 DONE: out_valid = 1; diff, borrow and of SHALL hold stable until out_valid && out_ready, then move to IDLE.
REQ-021 in_valid while BUSY or DONE SHALL be ignored and SHALL NOT disturb the latched operands.
REQ-022 out_ready while not in DONE SHALL have no effect.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH; the unsaturated diff SHALL always equal the low WIDTH bits of a - b - bin.

Reset
REQ-024 rst_n low at an edge SHALL force IDLE, digit counter 0, diff 0, borrow 0, of 0 and out_valid 0; in_ready SHALL be 1 after the reset edge.
REQ-025 Reset mid-operation SHALL abort the operation, and no out_valid SHALL be produced for it.

Configuration
REQ-026 Macro SERIAL_SUB_SAT_EN defined: when of = 1, diff SHALL saturate to 0x7FFF_FFFF if a[MSB] = 0, else to 0x8000_0000 (WIDTH-scaled); of and borrow are unchanged.
REQ-027 SERIAL_SUB_SAT_EN undefined: diff SHALL be the wrapped result, and the block SHALL contain no saturation logic.

Structure
REQ-028 Package serial_sub_pkg SHALL hold the FSM state enum and the default WIDTH and DIGIT constants.
REQ-029 Sub-module digit_sub SHALL implement one DIGIT-bit subtract slice (a_k, b_k, carry in; digit, carry out), instantiated once and reused every cycle.

Verification
REQ-030 Handshake: a=5, b=2, bin=1 -> diff=2, borrow=0, of=0; out_valid high exactly 4 edges after the accept edge.
REQ-031 Underflow: a=0, b=1, bin=0 -> diff=0xFFFF_FFFF, borrow=1, of=0.
REQ-032 Negative overflow: a=0x8000_0000, b=1 -> diff=0x7FFF_FFFF, of=1, borrow=0; with SERIAL_SUB_SAT_EN defined, diff=0x8000_0000.
REQ-033 Positive overflow: a=0x7FFF_FFFF, b=0xFFFF_FFFF -> diff=0x8000_0000, of=1, borrow=1; with SERIAL_SUB_SAT_EN defined, diff=0x7FFF_FFFF.
REQ-034 Backpressure: out_ready held low for 3 cycles in DONE -> outputs stable and in_ready=0; a new in_valid pulse during BUSY is ignored and the first result is unchanged.
REQ-035 Reset mid-operation: rst_n low while digit 2 is being processed -> next cycle IDLE, out_valid=0, diff=0, in_ready=1.
